cdc_handshake_rx: RTL and testbench

//   Receive end of the two-phase toggle handshake used by the synchronizer test chip.

---
 rtl/cdc_handshake_rx_pkg.sv | 17 +
 rtl/cdc_handshake_rx_bit_sync.sv | 27 ++
 rtl/cdc_handshake_rx.sv | 167 ++++++++++++++++
 tb/tb_cdc_handshake_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_handshake_rx_pkg.sv
// Shared definitions for the toggle-handshake receiver: FSM encodings and default sizing.
// The sender block imports the same package so both ends agree on encodings.
package cdc_handshake_rx_pkg;

    localparam int DEF_N           = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SETTLE      = 1;
    localparam int DEF_CNT_W       = 8;
    localparam int SETTLE_W        = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_VALID  = 2'd2;

endpackage

// File: rtl/cdc_handshake_rx_bit_sync.sv
// Generic single-bit synchronizer, STAGES flops deep, synchronous active-high reset.
// The sender reuses this for its ack_tog input.
module cdc_handshake_rx_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    assign sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_rx.sv
// Receive end of the two-phase toggle handshake: synchronize req, settle, capture the
// quasi-static bus onto a valid/ready port, return an ack toggle and keep sequence statistics.
//
// state  | meaning
// IDLE   | waiting for a pending request while enabled
// SETTLE | request seen, counting down before sampling data_a
// VALID  | captured word presented, waiting for out_ready
module cdc_handshake_rx
    import cdc_handshake_rx_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SETTLE      = DEF_SETTLE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_stats_i,
    input  logic             req_tog_i,
    input  logic [N-1:0]     data_a_i,
    output logic [N-1:0]     out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             ack_tog_o,
    output logic             busy_o,
    output logic             overrun_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE);

    logic                req_s;
    logic                pending;
    logic                capture;

    logic                req_seen_q,   req_seen_d;
    logic                req_prev_q;
    state_t              state_q,      state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [N-1:0]        out_data_q,   out_data_d;
    logic                out_valid_q,  out_valid_d;
    logic                ack_q,        ack_d;
    logic                overrun_q,    overrun_d;
    logic [CNT_W-1:0]    word_cnt_q,   word_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q,    err_cnt_d;
    logic [N-1:0]        exp_data_q,   exp_data_d;

    cdc_handshake_rx_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (req_tog_i),
        .q_o   (req_s)
    );

    // Level compare, so a toggle that lands while disabled stays pending.
    assign pending = (req_s != req_seen_q);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        req_seen_d   = req_seen_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        ack_d        = ack_q;
        overrun_d    = overrun_q;
        word_cnt_d   = word_cnt_q;
        err_cnt_d    = err_cnt_q;
        exp_data_d   = exp_data_q;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending && en_i) begin
                    if (SETTLE == 0) begin
                        capture = 1'b1;
                    end else begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_INIT;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(1)) begin
                    capture = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            ST_VALID: begin
                if (out_ready_i) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    ack_d       = ~ack_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            state_d      = ST_VALID;
            settle_cnt_d = '0;
            out_data_d   = data_a_i;
            out_valid_d  = 1'b1;
            req_seen_d   = req_s;
            word_cnt_d   = word_cnt_q + 1'b1;
            if ((data_a_i != exp_data_q) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            // Checker follows the received word so one glitch costs one error, not a stream.
            exp_data_d   = data_a_i + 1'b1;
        end

        if ((state_q != ST_IDLE) && (req_s != req_prev_q)) begin
            overrun_d = 1'b1;
        end

        if (clr_stats_i) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
            exp_data_d = '0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            req_seen_q   <= 1'b0;
            req_prev_q   <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            ack_q        <= 1'b0;
            overrun_q    <= 1'b0;
            word_cnt_q   <= '0;
            err_cnt_q    <= '0;
            exp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            req_seen_q   <= req_seen_d;
            req_prev_q   <= req_s;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            ack_q        <= ack_d;
            overrun_q    <= overrun_d;
            word_cnt_q   <= word_cnt_d;
            err_cnt_q    <= err_cnt_d;
            exp_data_q   <= exp_data_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign ack_tog_o   = ack_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign overrun_o   = overrun_q;
    assign word_cnt_o  = word_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench for cdc_handshake_rx: default instance plus a SETTLE=3 instance sharing the inputs.
module tb_cdc_handshake_rx;

    logic       clk = 1'b0;
    logic       rst, en, clr_stats, req_tog, out_ready;
    logic [7:0] data_a;

    logic [7:0] out_data, word_cnt, err_cnt;
    logic       out_valid, ack_tog, busy, overrun;
    logic [7:0] out_data3, word_cnt3, err_cnt3;
    logic       out_valid3, ack_tog3, busy3, overrun3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cdc_handshake_rx #(.N(8), .SYNC_STAGES(2), .SETTLE(1), .CNT_W(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_stats_i(clr_stats), .req_tog_i(req_tog),
        .data_a_i(data_a), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .ack_tog_o(ack_tog), .busy_o(busy), .overrun_o(overrun), .word_cnt_o(word_cnt),
        .err_cnt_o(err_cnt)
    );

    cdc_handshake_rx #(.N(8), .SYNC_STAGES(2), .SETTLE(3), .CNT_W(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_stats_i(clr_stats), .req_tog_i(req_tog),
        .data_a_i(data_a), .out_data_o(out_data3), .out_valid_o(out_valid3), .out_ready_i(out_ready),
        .ack_tog_o(ack_tog3), .busy_o(busy3), .overrun_o(overrun3), .word_cnt_o(word_cnt3),
        .err_cnt_o(err_cnt3)
    );

    typedef struct {
        logic [7:0] d;
        int         hold;
        logic [7:0] wc;
        logic [7:0] ec;
        logic       ack;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_tog = 1'b0; data_a = 8'h00; en = 1'b1; clr_stats = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Toggle a request, wait for the word, hold it for 'hold' cycles, then consume it.
    task automatic xfer(input logic [7:0] d, input int hold, input int lat_exp, input string tag);
        int   n;
        logic ack0;
        ack0      = ack_tog;
        out_ready = 1'b0;
        data_a    = d;
        req_tog   = ~req_tog;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 40);
        check({tag, " latency"}, n, lat_exp);
        check({tag, " data"}, out_data, d);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold"}, {out_valid, busy, ack_tog, out_data}, {1'b1, 1'b1, ack0, d});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " consumed"}, {out_valid, busy, ack_tog}, {1'b0, 1'b0, ~ack0});
    endtask

    task automatic wait_valid(input int lat_exp, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 40);
        check({tag, " latency"}, n, lat_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         m_wc, m_ec, m_exp;
        logic       m_ack;
        logic [7:0] d;
        int         n;

        vecs[0] = '{8'h00, 0,  8'd1, 8'd0, 1'b1};
        vecs[1] = '{8'h01, 10, 8'd2, 8'd0, 1'b0};
        vecs[2] = '{8'h05, 1,  8'd3, 8'd1, 1'b1};
        vecs[3] = '{8'h06, 0,  8'd4, 8'd1, 1'b0};
        vecs[4] = '{8'h06, 2,  8'd5, 8'd2, 1'b1};
        vecs[5] = '{8'hFF, 0,  8'd6, 8'd3, 1'b0};
        vecs[6] = '{8'h00, 3,  8'd7, 8'd3, 1'b1};
        vecs[7] = '{8'h01, 0,  8'd8, 8'd3, 1'b0};

        rst = 1'b1; req_tog = 1'b0; data_a = 8'h00; en = 1'b1; clr_stats = 1'b0; out_ready = 1'b0;
        do_reset();
        check("reset outputs", {out_data, out_valid, ack_tog, busy, overrun, word_cnt, err_cnt}, 0);

        // Out_ready tied high: two in-sequence words.
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            data_a  = 8'(w);
            req_tog = ~req_tog;
            n = 0;
            do begin
                tick();
                n++;
            end while (!out_valid && n < 40);
            check("tied latency", n, 4);
            check("tied data", out_data, w);
            tick();
            check("tied ack", {out_valid, ack_tog}, {1'b0, (w == 0) ? 1'b1 : 1'b0});
        end
        out_ready = 1'b0;
        check("tied stats", {word_cnt, err_cnt}, {8'd2, 8'd0});

        do_reset();
        for (int v = 0; v < 8; v++) begin
            xfer(vecs[v].d, vecs[v].hold, 4, "vec");
            check("vec stats", {word_cnt, err_cnt, 7'd0, ack_tog}, {vecs[v].wc, vecs[v].ec, 7'd0, vecs[v].ack});
        end

        do_reset();
        xfer(8'h05, 0, 4, "resync a");
        check("resync a err", err_cnt, 1);
        xfer(8'h06, 0, 4, "resync b");
        check("resync b err", err_cnt, 1);

        // Request while disabled stays pending and starts on the edge after en rises.
        en = 1'b0;
        data_a = 8'h07;
        req_tog = ~req_tog;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("en0 idle", {out_valid, busy}, 0);
        end
        en = 1'b1;
        tick();
        check("en1 settle", {busy, out_valid}, {1'b1, 1'b0});
        tick();
        check("en1 valid", {out_valid, out_data}, {1'b1, 8'h07});
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("en1 done", {ack_tog, word_cnt, err_cnt}, {1'b1, 8'd3, 8'd1});

        // Two toggles during VALID: overrun, no extra capture, cleared by clr_stats.
        data_a = 8'h08;
        req_tog = ~req_tog;
        wait_valid(4, "ovr");
        req_tog = ~req_tog;
        tick();
        req_tog = ~req_tog;
        for (int i = 0; i < 4; i++) tick();
        check("ovr set", {overrun, busy}, {1'b1, 1'b1});
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("ovr sticky", {overrun, busy, out_valid}, {1'b1, 1'b0, 1'b0});
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        check("clr stats", {overrun, word_cnt, err_cnt}, 0);

        // One toggle during VALID is served after returning to IDLE.
        data_a = 8'h00;
        req_tog = ~req_tog;
        wait_valid(4, "late");
        data_a = 8'h01;
        req_tog = ~req_tog;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("late consumed", {overrun, busy, out_valid}, {1'b1, 1'b0, 1'b0});
        tick();
        check("late settle", busy, 1);
        tick();
        check("late valid", {out_valid, out_data}, {1'b1, 8'h01});
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("late stats", {word_cnt, err_cnt}, {8'd2, 8'd0});

        // clr_stats on the capture edge wins over the statistics update.
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        data_a = 8'h33;
        req_tog = ~req_tog;
        for (int i = 0; i < 3; i++) tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr+cap", {out_valid, out_data, word_cnt, err_cnt}, {1'b1, 8'h33, 8'd0, 8'd0});
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        xfer(8'h00, 0, 4, "post clr");
        check("post clr stats", {word_cnt, err_cnt}, {8'd1, 8'd0});

        // Random traffic against a transaction-level model.
        do_reset();
        m_wc = 0; m_ec = 0; m_exp = 0; m_ack = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                clr_stats = 1'b1; tick(); clr_stats = 1'b0;
                m_wc = 0; m_ec = 0; m_exp = 0;
            end
            d = ($urandom_range(0, 1) == 1) ? 8'(m_exp) : 8'($urandom);
            xfer(d, int'($urandom_range(0, 4)), 4, "rnd");
            m_wc = (m_wc + 1) % 256;
            if (int'(d) != m_exp && m_ec < 255) m_ec = m_ec + 1;
            m_exp = (int'(d) + 1) % 256;
            m_ack = ~m_ack;
            check("rnd word_cnt", word_cnt, m_wc);
            check("rnd err_cnt", err_cnt, m_ec);
            check("rnd ack", ack_tog, m_ack);
        end

        // Reset in the middle of SETTLE on the SETTLE=3 instance.
        do_reset();
        data_a = 8'h40;
        req_tog = ~req_tog;
        for (int i = 0; i < 3; i++) tick();
        check("s3 in settle", {busy3, out_valid3}, {1'b1, 1'b0});
        rst = 1'b1;
        tick();
        check("s3 reset", {out_data3, out_valid3, ack_tog3, busy3, overrun3, word_cnt3, err_cnt3}, 0);
        req_tog = 1'b0; data_a = 8'h00;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        req_tog = ~req_tog;
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid3 && n < 40);
        check("s3 latency", n, 6);
        check("s3 data", out_data3, 0);
        tick();
        check("s3 done", {out_valid3, ack_tog3, word_cnt3, err_cnt3}, {1'b0, 1'b1, 8'd1, 8'd0});
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
